instr_fetch_unit: RTL and testbench

//  Instruction-side responder to the CPU controller. Owns the program counter (PC) and the

---
 rtl/instr_fetch_unit.sv | 154 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
// Instruction-side responder to the CPU controller. Owns the program counter
// and the instruction register, and fetches one opcode byte per LoadIR
// request from instruction memory over a req/ack handshake. A fetch that
// sees no MemAck within TIMEOUT cycles ends with a NOP opcode and a sticky
// FetchErr flag.
//
// Ports
//   clk       in   1         system clock, rising edge
//   reset     in   1         asynchronous, active-high reset
//   LoadIR    in   1         start a fetch at the current PC (acted on in IDLE)
//   IncPC     in   1         PC <= PC + 1
//   LoadPC    in   1         PC <= SelPC ? ImmData : RegData (beats IncPC)
//   SelPC     in   1         PC source select: 0 = RegData, 1 = ImmData
//   RegData   in   PC_WIDTH  jump target from register file
//   ImmData   in   PC_WIDTH  jump target from controller immediate
//   MemAddr   out  PC_WIDTH  fetch address, stable while MemReq is high
//   MemReq    out  1         fetch request, held until MemAck or timeout
//   MemAck    in   1         memory response, MemData valid in same cycle
//   MemData   in   8         instruction byte
//   Opcode    out  8         IR contents
//   IRValid   out  1         IR holds the result of the most recent fetch
//   Busy      out  1         high while a fetch is in flight
//   FetchErr  out  1         last fetch timed out; cleared at next fetch start
//   PC        out  PC_WIDTH  current program counter
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int unsigned PC_WIDTH = 8,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                LoadIR,
    input  logic                IncPC,
    input  logic                LoadPC,
    input  logic                SelPC,
    input  logic [PC_WIDTH-1:0] RegData,
    input  logic [PC_WIDTH-1:0] ImmData,
    output logic [PC_WIDTH-1:0] MemAddr,
    output logic                MemReq,
    input  logic                MemAck,
    input  logic [7:0]          MemData,
    output logic [7:0]          Opcode,
    output logic                IRValid,
    output logic                Busy,
    output logic                FetchErr,
    output logic [PC_WIDTH-1:0] PC
);

    // TIMEOUT is limited to 1..255, so an 8-bit wait counter always suffices
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [7:0]       NOP      = 8'h00;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FETCH = 1'b1
    } state_t;

    state_t              r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] r_mem_addr;
    logic                r_mem_req;
    logic [7:0]          r_opcode;
    logic                r_ir_valid;
    logic                r_busy;
    logic                r_fetch_err;
    logic [CNT_W-1:0]    r_wait_cnt;

    logic [PC_WIDTH-1:0] w_pc_next;
    logic                w_wait_expired;

    // Next PC: a load beats an increment; increment wraps naturally
    always_comb begin
        w_pc_next = r_pc;
        if (LoadPC) begin
            w_pc_next = SelPC ? ImmData : RegData;
        end else if (IncPC) begin
            w_pc_next = r_pc + PC_WIDTH'(1);
        end
    end

    assign w_wait_expired = (r_wait_cnt == CNT_LAST);

    // PC register runs independently of the fetch FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= PC_WIDTH'(RESET_PC);
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // Fetch FSM; the fetch address is captured from the pre-update PC
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_mem_addr  <= '0;
            r_mem_req   <= 1'b0;
            r_opcode    <= NOP;
            r_ir_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_fetch_err <= 1'b0;
            r_wait_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (LoadIR) begin
                        r_state     <= S_FETCH;
                        r_mem_addr  <= r_pc;
                        r_mem_req   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_ir_valid  <= 1'b0;
                        r_fetch_err <= 1'b0;
                        r_wait_cnt  <= '0;
                    end
                end
                S_FETCH: begin
                    if (MemAck) begin
                        r_state    <= S_IDLE;
                        r_opcode   <= MemData;
                        r_ir_valid <= 1'b1;
                        r_mem_req  <= 1'b0;
                        r_busy     <= 1'b0;
                    end else if (w_wait_expired) begin
                        // Abort: hand the controller a NOP and flag the error
                        r_state     <= S_IDLE;
                        r_opcode    <= NOP;
                        r_ir_valid  <= 1'b1;
                        r_fetch_err <= 1'b1;
                        r_mem_req   <= 1'b0;
                        r_busy      <= 1'b0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign MemAddr  = r_mem_addr;
    assign MemReq   = r_mem_req;
    assign Opcode   = r_opcode;
    assign IRValid  = r_ir_valid;
    assign Busy     = r_busy;
    assign FetchErr = r_fetch_err;
    assign PC       = r_pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam int unsigned TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic       LoadIR, IncPC, LoadPC, SelPC;
    logic [7:0] RegData, ImmData;
    logic [7:0] MemAddr;
    logic       MemReq;
    logic       MemAck;
    logic [7:0] MemData;
    logic [7:0] Opcode;
    logic       IRValid, Busy, FetchErr;
    logic [7:0] PC;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mem [256];

    instr_fetch_unit #(.PC_WIDTH(8), .RESET_PC(0), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .LoadIR(LoadIR), .IncPC(IncPC), .LoadPC(LoadPC), .SelPC(SelPC),
        .RegData(RegData), .ImmData(ImmData),
        .MemAddr(MemAddr), .MemReq(MemReq), .MemAck(MemAck), .MemData(MemData),
        .Opcode(Opcode), .IRValid(IRValid), .Busy(Busy), .FetchErr(FetchErr),
        .PC(PC)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        LoadIR = 0; IncPC = 0; LoadPC = 0; SelPC = 0;
        RegData = 0; ImmData = 0; MemAck = 0; MemData = 0;
    endtask

    task automatic set_pc(input logic [7:0] v);
        @(negedge clk);
        quiet_inputs();
        LoadPC = 1; SelPC = 1; ImmData = v;
        tick();
        @(negedge clk);
        quiet_inputs();
    endtask

    task automatic test_reset();
        set_pc(8'h5A);
        LoadIR = 1;
        tick();
        @(negedge clk);
        LoadIR = 0;
        // Assert reset mid-cycle, away from any clock edge
        #2 reset = 1;
        #1;
        n_cmp++;
        if ({PC, Opcode, MemAddr, MemReq, IRValid, Busy, FetchErr} !== {8'h00, 8'h00, 8'h00, 4'b0000}) begin
            n_err++;
            $display("FAIL reset_async: got PC=%h Op=%h Addr=%h Req=%b V=%b B=%b E=%b want all zero",
                     PC, Opcode, MemAddr, MemReq, IRValid, Busy, FetchErr);
        end
        // Edges under reset change nothing
        LoadIR = 1; IncPC = 1;
        tick();
        n_cmp++;
        if ({PC, MemReq, Busy} !== {8'h00, 2'b00}) begin
            n_err++;
            $display("FAIL reset_hold: got PC=%h Req=%b Busy=%b want 00 0 0", PC, MemReq, Busy);
        end
        @(negedge clk);
        quiet_inputs();
        reset = 0;
    endtask

    task automatic test_fetch_latency();
        set_pc(8'h05);
        LoadIR = 1;
        tick();                       // edge 1: enter FETCH
        n_cmp++;
        if (MemAddr !== 8'h05 || MemReq !== 1'b1 || Busy !== 1'b1 || IRValid !== 1'b0) begin
            n_err++;
            $display("FAIL fetch_start: got Addr=%h Req=%b Busy=%b V=%b want 05 1 1 0",
                     MemAddr, MemReq, Busy, IRValid);
        end
        @(negedge clk); LoadIR = 0;
        tick();                       // edge 2: wait 1
        tick();                       // edge 3: wait 2
        n_cmp++;
        if (IRValid !== 1'b0 || MemReq !== 1'b1) begin
            n_err++;
            $display("FAIL fetch_wait: got V=%b Req=%b want 0 1", IRValid, MemReq);
        end
        @(negedge clk); MemAck = 1; MemData = 8'h43;
        tick();                       // edge 4: ack
        n_cmp++;
        if (Opcode !== 8'h43 || IRValid !== 1'b1 || MemReq !== 1'b0 || Busy !== 1'b0 || PC !== 8'h05) begin
            n_err++;
            $display("FAIL fetch_done: got Op=%h V=%b Req=%b Busy=%b PC=%h want 43 1 0 0 05",
                     Opcode, IRValid, MemReq, Busy, PC);
        end
        // Ack while idle is ignored
        @(negedge clk); MemData = 8'hEE;
        tick();
        n_cmp++;
        if (Opcode !== 8'h43 || Busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_ack: got Op=%h Busy=%b want 43 0", Opcode, Busy);
        end
        @(negedge clk); quiet_inputs();
    endtask

    task automatic test_pc_wrap();
        set_pc(8'hFF);
        n_cmp++;
        if (PC !== 8'hFF) begin
            n_err++;
            $display("FAIL pc_load: got %h want ff", PC);
        end
        IncPC = 1;
        tick();
        n_cmp++;
        if (PC !== 8'h00) begin
            n_err++;
            $display("FAIL pc_wrap: got %h want 00", PC);
        end
        @(negedge clk);
        LoadPC = 1; IncPC = 1; SelPC = 0; RegData = 8'h21; ImmData = 8'h99;
        tick();
        n_cmp++;
        if (PC !== 8'h21) begin
            n_err++;
            $display("FAIL pc_priority: got %h want 21", PC);
        end
        @(negedge clk); quiet_inputs();
        tick();
        n_cmp++;
        if (PC !== 8'h21) begin
            n_err++;
            $display("FAIL pc_hold: got %h want 21", PC);
        end
    endtask

    task automatic test_jump_during_fetch();
        set_pc(8'h10);
        LoadIR = 1;
        tick();
        @(negedge clk);
        LoadIR = 1;                   // ignored while fetching
        LoadPC = 1; SelPC = 1; ImmData = 8'h3C; RegData = 8'h77;
        tick();
        n_cmp++;
        if (PC !== 8'h3C || MemAddr !== 8'h10 || MemReq !== 1'b1) begin
            n_err++;
            $display("FAIL jump_inflight: got PC=%h Addr=%h Req=%b want 3c 10 1", PC, MemAddr, MemReq);
        end
        @(negedge clk);
        quiet_inputs();
        MemAck = 1; MemData = mem[MemAddr];
        tick();
        n_cmp++;
        if (Opcode !== mem[8'h10] || IRValid !== 1'b1 || PC !== 8'h3C) begin
            n_err++;
            $display("FAIL jump_opcode: got Op=%h V=%b PC=%h want %h 1 3c", Opcode, IRValid, PC, mem[8'h10]);
        end
        @(negedge clk); quiet_inputs();
    endtask

    task automatic test_timeout();
        LoadIR = 1;
        tick();
        @(negedge clk); LoadIR = 0;
        for (int k = 0; k < int'(TIMEOUT) - 1; k++) tick();
        n_cmp++;
        if (MemReq !== 1'b1 || FetchErr !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_early: got Req=%b Err=%b want 1 0", MemReq, FetchErr);
        end
        tick();
        n_cmp++;
        if (MemReq !== 1'b0 || Opcode !== 8'h00 || IRValid !== 1'b1 || FetchErr !== 1'b1 || Busy !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_abort: got Req=%b Op=%h V=%b Err=%b Busy=%b want 0 00 1 1 0",
                     MemReq, Opcode, IRValid, FetchErr, Busy);
        end
        @(negedge clk); LoadIR = 1;
        tick();
        n_cmp++;
        if (FetchErr !== 1'b0 || IRValid !== 1'b0 || MemReq !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_clear: got Err=%b V=%b Req=%b want 0 0 1", FetchErr, IRValid, MemReq);
        end
        @(negedge clk); quiet_inputs(); MemAck = 1; MemData = mem[MemAddr];
        tick();
        @(negedge clk); quiet_inputs();
    endtask

    task automatic test_reset_during_fetch();
        LoadIR = 1;
        tick();
        @(negedge clk); LoadIR = 0;
        tick();
        #2 reset = 1;
        #1;
        n_cmp++;
        if (MemReq !== 1'b0 || Busy !== 1'b0 || IRValid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_fetch: got Req=%b Busy=%b V=%b want 0 0 0", MemReq, Busy, IRValid);
        end
        @(negedge clk); reset = 0;
        MemAck = 1; MemData = 8'hA5;
        tick();
        tick();
        n_cmp++;
        if (IRValid !== 1'b0 || Opcode !== 8'h00 || Busy !== 1'b0 || MemReq !== 1'b0) begin
            n_err++;
            $display("FAIL late_ack: got V=%b Op=%h Busy=%b Req=%b want 0 00 0 0", IRValid, Opcode, Busy, MemReq);
        end
        @(negedge clk); quiet_inputs();
    endtask

    // Randomised transactions against a transaction-level model:
    // expected opcode = mem[PC at request] unless the ack latency reaches TIMEOUT.
    task automatic test_random();
        logic [7:0] m_pc;
        logic [7:0] exp_addr;
        int         lat;
        bit         timed_out;
        bit         ld, inc, sel;
        logic [7:0] rd, im;
        m_pc = PC;                    // model seeded once from a checked-known state
        for (int t = 0; t < 40; t++) begin
            lat = $urandom_range(0, 18);
            timed_out = (lat >= int'(TIMEOUT));
            @(negedge clk);
            ld = 1'($urandom); inc = 1'($urandom); sel = 1'($urandom);
            rd = 8'($urandom); im = 8'($urandom);
            LoadIR = 1; LoadPC = ld; IncPC = inc; SelPC = sel; RegData = rd; ImmData = im;
            MemAck = 1'($urandom); MemData = 8'($urandom);
            exp_addr = m_pc;
            m_pc = ld ? (sel ? im : rd) : (inc ? m_pc + 8'd1 : m_pc);
            tick();
            n_cmp++;
            if (MemAddr !== exp_addr || MemReq !== 1'b1 || PC !== m_pc || FetchErr !== 1'b0) begin
                n_err++;
                $display("FAIL rnd_start[%0d]: got Addr=%h Req=%b PC=%h Err=%b want %h 1 %h 0",
                         t, MemAddr, MemReq, PC, FetchErr, exp_addr, m_pc);
            end
            for (int k = 0; k < int'(TIMEOUT); k++) begin
                @(negedge clk);
                ld = 1'($urandom); inc = 1'($urandom); sel = 1'($urandom);
                rd = 8'($urandom); im = 8'($urandom);
                LoadIR = 1'($urandom); LoadPC = ld; IncPC = inc; SelPC = sel;
                RegData = rd; ImmData = im;
                MemAck = (k == lat);
                MemData = (k == lat) ? mem[MemAddr] : 8'($urandom);
                m_pc = ld ? (sel ? im : rd) : (inc ? m_pc + 8'd1 : m_pc);
                tick();
                if (k == lat || k == int'(TIMEOUT) - 1) break;
            end
            n_cmp++;
            if (Opcode !== (timed_out ? 8'h00 : mem[exp_addr]) || IRValid !== 1'b1 ||
                FetchErr !== timed_out || MemReq !== 1'b0 || Busy !== 1'b0 || PC !== m_pc) begin
                n_err++;
                $display("FAIL rnd_done[%0d]: got Op=%h V=%b Err=%b Req=%b Busy=%b PC=%h want %h 1 %b 0 0 %h",
                         t, Opcode, IRValid, FetchErr, MemReq, Busy, PC,
                         timed_out ? 8'h00 : mem[exp_addr], timed_out, m_pc);
            end
            @(negedge clk);
            quiet_inputs();
            MemAck = 1'($urandom);
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        quiet_inputs();
        reset = 1;
        #12;
        @(negedge clk);
        reset = 0;
        test_reset();
        test_fetch_latency();
        test_pc_wrap();
        test_jump_during_fetch();
        test_timeout();
        test_reset_during_fetch();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
